// File: rtl/load_buffer.sv
// Out-of-order load buffer: captures dispatched loads, computes addresses, tracks
// older-store dependences, issues to the Dcache and broadcasts results on the CDB.
package load_buffer_pkg;
  localparam int unsigned LB_SIZE  = 8;
  localparam int unsigned LB_BITS  = 3;
  localparam int unsigned SQ_SIZE  = 16;
  localparam int unsigned SQ_BITS  = 4;
  localparam int unsigned PR_BITS  = 6;
  localparam int unsigned ROB_BITS = 5;
  localparam int unsigned XLEN     = 64;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     FU_result;
    logic [PR_BITS-1:0]  PRN;
    logic [ROB_BITS-1:0] ROB_index;
    logic                thread_ID;
    logic                mispredict;
    logic                branch_actually_taken;
  } cdb_t;

  typedef struct packed {
    logic               valid;
    logic               stc_mem;
    logic [SQ_BITS-1:0] sq_index;
    logic [XLEN-1:0]    sq_address;
  } resolved_store_t;

  typedef struct packed {
    logic [SQ_SIZE-1:0]           valid;
    logic [SQ_SIZE-1:0]           stc_mem;
    logic [SQ_SIZE-1:0]           address_resolved;
    logic [SQ_SIZE-1:0][XLEN-1:0] address;
  } all_stores_t;

  typedef struct packed {
    logic               valid;
    logic [SQ_BITS-1:0] sq_index;
    logic [XLEN-1:0]    sq_address;
    logic [XLEN-1:0]    sq_value;
  } committed_store_t;

  typedef struct packed {
    logic                dispatch;
    logic                rd_mem;
    logic                wr_mem;
    logic                ldl_mem;
    logic                stc_mem;
    logic                thread_ID;
    logic                base_addr_ready;
    logic [XLEN-1:0]     base_addr;
    logic [PR_BITS-1:0]  base_addr_PRN;
    logic [XLEN-1:0]     offset;
    logic [PR_BITS-1:0]  PRN_dest;
    logic [ROB_BITS-1:0] ROB_index;
    logic [XLEN-1:0]     value_to_store;
    logic                value_to_store_ready;
    logic [PR_BITS-1:0]  op1_PRN;
  } inst_t;

  typedef struct packed {
    logic                valid;
    logic                base_ready;
    logic [XLEN-1:0]     base;
    logic [PR_BITS-1:0]  base_prn;
    logic [XLEN-1:0]     offset;
    logic [PR_BITS-1:0]  prn_dest;
    logic [ROB_BITS-1:0] rob_index;
    logic                thread_id;
    logic                ldl;
    logic                addr_done;
    logic [XLEN-1:0]     addr;
    logic [SQ_SIZE-1:0]  mask;
    logic                requested;
    logic                done;
    logic [XLEN-1:0]     data;
  } lb_entry_t;
endpackage

module load_buffer
  import load_buffer_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Dcache_valid,
  input  logic [XLEN-1:0]        Dcache_data,
  input  logic [LB_BITS-1:0]     Dcache_index,
  input  logic                   Dcache_req_successful,
  input  logic                   Memory_valid,
  input  logic [XLEN-1:0]        Memory_data,
  input  logic [LB_BITS-1:0]     Memory_index,
  input  cdb_t                   CDB_0,
  input  cdb_t                   CDB_1,
  input  resolved_store_t        resolved_store,
  input  all_stores_t            all_stores,
  input  committed_store_t [1:0] committed_stores,
  input  inst_t [1:0]            inst_in,
  input  logic [SQ_BITS-1:0]     sq_head_index,
  input  logic [SQ_BITS-1:0]     sq_tail_index,
  input  logic                   mispredict,
  output logic                   almost_full,
  output logic                   full,
  output logic                   valid_request,
  output logic [LB_BITS-1:0]     proc2Dcache_index,
  output logic [XLEN-1:0]        proc2Dcache_addr,
  output cdb_t                   output_to_CDB,
  output logic                   output_ldl_mem,
  output logic [XLEN-1:0]        output_addr,
  output logic [LB_BITS:0]       count
);
  localparam int unsigned CNT_W = LB_BITS + 1;

  lb_entry_t          ent      [LB_SIZE];
  lb_entry_t          ent_next [LB_SIZE];
  lb_entry_t          new_ent  [2];
  logic               want0, want1, found0, found1, take0, take1;
  logic [LB_BITS-1:0] slot0, slot1;
  logic               add_found, req_found, bc_found;
  logic [LB_BITS-1:0] add_idx, req_idx, bc_idx;
  logic [SQ_BITS-1:0] sq_span;
  logic [CNT_W-1:0]   count_next;
  logic               unused_sig;

  assign unused_sig = ^{inst_in, CDB_0, CDB_1, resolved_store.stc_mem, all_stores.stc_mem};

  // Priority pickers: free slots for both lanes, adder, issue and broadcast
  always_comb begin
    want0 = inst_in[0].dispatch && (inst_in[0].rd_mem || inst_in[0].ldl_mem);
    want1 = inst_in[1].dispatch && (inst_in[1].rd_mem || inst_in[1].ldl_mem);
    found0 = 1'b0; slot0 = '0;
    found1 = 1'b0; slot1 = '0;
    add_found = 1'b0; add_idx = '0;
    req_found = 1'b0; req_idx = '0;
    bc_found = 1'b0; bc_idx = '0;
    for (int i = int'(LB_SIZE) - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        found0 = 1'b1; slot0 = LB_BITS'(i);
      end
      if (ent[i].valid && ent[i].base_ready && !ent[i].addr_done) begin
        add_found = 1'b1; add_idx = LB_BITS'(i);
      end
      if (ent[i].valid && ent[i].addr_done && (ent[i].mask == '0) &&
          !ent[i].requested && !ent[i].done) begin
        req_found = 1'b1; req_idx = LB_BITS'(i);
      end
      if (ent[i].valid && ent[i].done) begin
        bc_found = 1'b1; bc_idx = LB_BITS'(i);
      end
    end
    take0 = want0 && found0;
    for (int i = int'(LB_SIZE) - 1; i >= 0; i--) begin
      if (!ent[i].valid && !(take0 && (slot0 == LB_BITS'(i)))) begin
        found1 = 1'b1; slot1 = LB_BITS'(i);
      end
    end
    take1 = want1 && found1;
  end

  // Newly dispatched entries, including same-cycle CDB capture and older-store mask
  always_comb begin
    sq_span = SQ_BITS'(sq_head_index - sq_tail_index);
    for (int k = 0; k < 2; k++) begin
      new_ent[k]            = '0;
      new_ent[k].valid      = 1'b1;
      new_ent[k].base_ready = inst_in[k].base_addr_ready;
      new_ent[k].base       = inst_in[k].base_addr;
      new_ent[k].base_prn   = inst_in[k].base_addr_PRN;
      new_ent[k].offset     = inst_in[k].offset;
      new_ent[k].prn_dest   = inst_in[k].PRN_dest;
      new_ent[k].rob_index  = inst_in[k].ROB_index;
      new_ent[k].thread_id  = inst_in[k].thread_ID;
      new_ent[k].ldl        = inst_in[k].ldl_mem;
      if (!inst_in[k].base_addr_ready) begin
        if (CDB_0.valid && (CDB_0.PRN == inst_in[k].base_addr_PRN)) begin
          new_ent[k].base_ready = 1'b1;
          new_ent[k].base       = CDB_0.FU_result;
        end else if (CDB_1.valid && (CDB_1.PRN == inst_in[k].base_addr_PRN)) begin
          new_ent[k].base_ready = 1'b1;
          new_ent[k].base       = CDB_1.FU_result;
        end
      end
      for (int j = 0; j < int'(SQ_SIZE); j++) begin
        new_ent[k].mask[j] = all_stores.valid[j] &&
                             (SQ_BITS'(sq_head_index - SQ_BITS'(j)) < sq_span);
      end
    end
  end

  // Per-entry next state
  always_comb begin
    for (int i = 0; i < int'(LB_SIZE); i++) begin
      ent_next[i] = ent[i];
      if (ent[i].valid) begin
        if (!ent[i].base_ready) begin
          if (CDB_0.valid && (CDB_0.PRN == ent[i].base_prn)) begin
            ent_next[i].base_ready = 1'b1;
            ent_next[i].base       = CDB_0.FU_result;
          end else if (CDB_1.valid && (CDB_1.PRN == ent[i].base_prn)) begin
            ent_next[i].base_ready = 1'b1;
            ent_next[i].base       = CDB_1.FU_result;
          end
        end
        if (add_found && (add_idx == LB_BITS'(i))) begin
          ent_next[i].addr      = ent[i].base + ent[i].offset;
          ent_next[i].addr_done = 1'b1;
        end
        for (int j = 0; j < int'(SQ_SIZE); j++) begin
          if (ent[i].mask[j]) begin
            if (ent[i].addr_done) begin
              if (all_stores.address_resolved[j] && (all_stores.address[j] != ent[i].addr))
                ent_next[i].mask[j] = 1'b0;
              if (resolved_store.valid && (resolved_store.sq_index == SQ_BITS'(j)) &&
                  (resolved_store.sq_address != ent[i].addr))
                ent_next[i].mask[j] = 1'b0;
            end
            // A retiring store always releases the load; a matching one forwards its data
            for (int c = 0; c < 2; c++) begin
              if (committed_stores[c].valid && (committed_stores[c].sq_index == SQ_BITS'(j))) begin
                ent_next[i].mask[j] = 1'b0;
                if (ent[i].addr_done && (committed_stores[c].sq_address == ent[i].addr) &&
                    !ent[i].done) begin
                  ent_next[i].data = committed_stores[c].sq_value;
                  ent_next[i].done = 1'b1;
                end
              end
            end
          end
        end
        if (req_found && (req_idx == LB_BITS'(i)) && Dcache_req_successful)
          ent_next[i].requested = 1'b1;
        if (Dcache_valid && (Dcache_index == LB_BITS'(i))) begin
          ent_next[i].data = Dcache_data;
          ent_next[i].done = 1'b1;
        end
        if (Memory_valid && (Memory_index == LB_BITS'(i))) begin
          ent_next[i].data = Memory_data;
          ent_next[i].done = 1'b1;
        end
        if (bc_found && (bc_idx == LB_BITS'(i)))
          ent_next[i] = '0;
      end else if (take0 && (slot0 == LB_BITS'(i))) begin
        ent_next[i] = new_ent[0];
      end else if (take1 && (slot1 == LB_BITS'(i))) begin
        ent_next[i] = new_ent[1];
      end
    end
    count_next = count + CNT_W'(take0) + CNT_W'(take1) - CNT_W'(bc_found);
  end

  // Request and broadcast drive straight from the pickers
  always_comb begin
    valid_request     = req_found;
    proc2Dcache_index = req_idx;
    proc2Dcache_addr  = req_found ? ent[req_idx].addr : '0;
    output_to_CDB     = '0;
    output_ldl_mem    = 1'b0;
    output_addr       = '0;
    if (bc_found) begin
      output_to_CDB.valid     = 1'b1;
      output_to_CDB.FU_result = ent[bc_idx].data;
      output_to_CDB.PRN       = ent[bc_idx].prn_dest;
      output_to_CDB.ROB_index = ent[bc_idx].rob_index;
      output_to_CDB.thread_ID = ent[bc_idx].thread_id;
      output_ldl_mem          = ent[bc_idx].ldl;
      output_addr             = ent[bc_idx].addr;
    end
  end

  assign full        = (count == CNT_W'(LB_SIZE));
  assign almost_full = (count >= CNT_W'(LB_SIZE - 1));

  always_ff @(posedge clock) begin
    if (reset || mispredict) begin
      for (int i = 0; i < int'(LB_SIZE); i++) ent[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < int'(LB_SIZE); i++) ent[i] <= ent_next[i];
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with request and broadcast scoreboards.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic Dcache_valid, Dcache_req_successful, Memory_valid, mispredict;
  logic [63:0] Dcache_data, Memory_data, proc2Dcache_addr, output_addr;
  logic [2:0] Dcache_index, Memory_index, proc2Dcache_index;
  cdb_t cdb0, cdb1, output_to_CDB;
  resolved_store_t rs;
  all_stores_t as_st;
  committed_store_t [1:0] cs;
  inst_t [1:0] ins;
  logic [3:0] head, tail;
  logic almost_full, full, valid_request, output_ldl_mem;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  prn;
    logic [4:0]  rob;
  } bc_t;
  bc_t         bc_q[$];
  logic [63:0] req_q[$];

  load_buffer dut (
    .clock(clock), .reset(reset),
    .Dcache_valid(Dcache_valid), .Dcache_data(Dcache_data), .Dcache_index(Dcache_index),
    .Dcache_req_successful(Dcache_req_successful),
    .Memory_valid(Memory_valid), .Memory_data(Memory_data), .Memory_index(Memory_index),
    .CDB_0(cdb0), .CDB_1(cdb1), .resolved_store(rs), .all_stores(as_st),
    .committed_stores(cs), .inst_in(ins),
    .sq_head_index(head), .sq_tail_index(tail), .mispredict(mispredict),
    .almost_full(almost_full), .full(full), .valid_request(valid_request),
    .proc2Dcache_index(proc2Dcache_index), .proc2Dcache_addr(proc2Dcache_addr),
    .output_to_CDB(output_to_CDB), .output_ldl_mem(output_ldl_mem),
    .output_addr(output_addr), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    Dcache_valid = 0; Dcache_data = '0; Dcache_index = '0; Dcache_req_successful = 0;
    Memory_valid = 0; Memory_data = '0; Memory_index = '0;
    cdb0 = '0; cdb1 = '0; rs = '0; as_st = '0; cs = '0; ins = '0;
    head = '0; tail = '0; mispredict = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_load(input int lane, input logic rdy, input logic [63:0] base,
                          input logic [5:0] prn, input logic [63:0] off,
                          input logic [5:0] dest, input logic [4:0] rob);
    inst_t t;
    t = '0;
    t.dispatch = 1; t.rd_mem = 1; t.base_addr_ready = rdy; t.base_addr = base;
    t.base_addr_PRN = prn; t.offset = off; t.PRN_dest = dest; t.ROB_index = rob;
    ins[lane] = t;
  endtask

  task automatic expect_req(input int budget);
    int n;
    logic [63:0] e;
    n = 0;
    while (!valid_request && n < budget) begin tick(); n++; end
    if (!valid_request || req_q.size() == 0) check("req_timeout", {63'd0, valid_request}, 64'd2);
    else begin
      e = req_q.pop_front();
      check("req_addr", proc2Dcache_addr, e);
    end
  endtask

  task automatic expect_bcast(input int budget);
    int n;
    bc_t e;
    n = 0;
    while (!output_to_CDB.valid && n < budget) begin tick(); n++; end
    if (!output_to_CDB.valid || bc_q.size() == 0) check("bcast_timeout", {63'd0, output_to_CDB.valid}, 64'd2);
    else begin
      e = bc_q.pop_front();
      check("bcast_data", output_to_CDB.FU_result, e.data);
      check("bcast_prn", 64'(output_to_CDB.PRN), 64'(e.prn));
      check("bcast_rob", 64'(output_to_CDB.ROB_index), 64'(e.rob));
    end
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    check("rst_afull", 64'(almost_full), 0);
    check("rst_vreq", 64'(valid_request), 0);
    check("rst_cdb", 64'(output_to_CDB.valid), 0);

    // fill all eight entries, two per cycle
    head = 4'd15; tail = 4'd11;
    for (int c = 0; c < 3; c++) begin
      set_load(0, 1, 64'h600, 0, 64'h200, 6'(2*c), 5'(2*c));
      set_load(1, 1, 64'h600, 0, 64'h200, 6'(2*c+1), 5'(2*c+1));
      tick();
    end
    check("fill6_count", 64'(count), 6);
    check("fill6_afull", 64'(almost_full), 0);
    set_load(0, 1, 64'h600, 0, 64'h200, 6, 6);
    set_load(1, 1, 64'h600, 0, 64'h200, 7, 7);
    tick();
    check("fill8_count", 64'(count), 8);
    check("fill8_full", 64'(full), 1);
    check("fill8_afull", 64'(almost_full), 1);
    ins[1] = '0;
    set_load(0, 1, 64'h600, 0, 64'h200, 9, 9);
    tick();
    ins = '0;
    check("drop_count", 64'(count), 8);
    req_q.push_back(64'h800);
    expect_req(0);
    check("req_idx0", 64'(proc2Dcache_index), 0);
    Dcache_req_successful = 1;
    tick();
    Dcache_req_successful = 0;
    check("req_idx1", 64'(proc2Dcache_index), 1);
    Memory_valid = 1; Memory_index = 0; Memory_data = 64'hAB;
    bc_q.push_back('{data: 64'hAB, prn: 6'd0, rob: 5'd0});
    tick();
    Memory_valid = 0;
    expect_bcast(1);
    check("bcast_addr", output_addr, 64'h800);
    tick();
    check("free_count", 64'(count), 7);
    check("free_cdb", 64'(output_to_CDB.valid), 0);

    // base via CDB_0, CDB_0 wins tie with CDB_1
    do_reset();
    head = 4'd15; tail = 4'd12;
    set_load(0, 0, 64'h0, 15, 64'h0, 3, 4);
    tick();
    ins = '0;
    check("cdb_wait_vreq", 64'(valid_request), 0);
    cdb0.valid = 1; cdb0.PRN = 15; cdb0.FU_result = 64'd100;
    cdb1.valid = 1; cdb1.PRN = 15; cdb1.FU_result = 64'd999;
    tick();
    cdb0 = '0; cdb1 = '0;
    check("cdb_add_vreq", 64'(valid_request), 0);
    tick();
    req_q.push_back(64'd100);
    expect_req(0);

    // matching resolved older store blocks, then forwards on commit
    do_reset();
    head = 4'd15; tail = 4'd12;
    as_st.valid[15] = 1; as_st.valid[14] = 1; as_st.valid[13] = 1;
    as_st.address_resolved[15] = 1; as_st.address_resolved[14] = 1; as_st.address_resolved[13] = 1;
    as_st.address[15] = 64'h200; as_st.address[14] = 64'h300; as_st.address[13] = 64'h400;
    set_load(0, 1, 64'h200, 0, 64'h0, 5, 6);
    tick();
    ins = '0;
    tick(); tick(); tick();
    check("match_vreq", 64'(valid_request), 0);
    cs[0].valid = 1; cs[0].sq_index = 15; cs[0].sq_address = 64'h200; cs[0].sq_value = 64'h5555;
    bc_q.push_back('{data: 64'h5555, prn: 6'd5, rob: 5'd6});
    tick();
    cs = '0;
    expect_bcast(1);

    // unresolved store blocks, same-address resolve keeps blocking
    do_reset();
    head = 4'd15; tail = 4'd14;
    as_st.valid[15] = 1;
    set_load(0, 1, 64'h200, 0, 64'h0, 1, 1);
    tick();
    ins = '0;
    tick(); tick();
    check("unres_vreq", 64'(valid_request), 0);
    rs.valid = 1; rs.sq_index = 15; rs.sq_address = 64'h200;
    as_st.address_resolved[15] = 1; as_st.address[15] = 64'h200;
    tick();
    rs = '0;
    tick();
    check("same_addr_vreq", 64'(valid_request), 0);

    // five older stores; CDB_1 captured at dispatch; release by non-matching resolves
    do_reset();
    head = 4'd15; tail = 4'd10;
    for (int j = 11; j < 16; j++) as_st.valid[j] = 1;
    as_st.valid[10] = 1;
    as_st.address_resolved[12] = 1; as_st.address[12] = 64'h600;
    as_st.address_resolved[11] = 1; as_st.address[11] = 64'h700;
    set_load(0, 0, 64'h0, 30, 64'h0, 7, 8);
    cdb1.valid = 1; cdb1.PRN = 30; cdb1.FU_result = 64'd100;
    tick();
    ins = '0; cdb1 = '0;
    tick(); tick();
    check("older5_vreq", 64'(valid_request), 0);
    rs.valid = 1; rs.sq_index = 15; rs.sq_address = 64'h1000;
    as_st.address_resolved[14] = 1; as_st.address[14] = 64'h1000;
    as_st.address_resolved[13] = 1; as_st.address[13] = 64'h1000;
    req_q.push_back(64'd100);
    tick();
    rs = '0;
    expect_req(0);

    // eight loads on PRN 30: one address per cycle, head==tail means no older stores
    do_reset();
    head = 4'd5; tail = 4'd5;
    as_st.valid = '1;
    for (int c = 0; c < 4; c++) begin
      set_load(0, 0, 64'h0, 30, 64'(16*c), 6'(2*c+8), 5'(2*c));
      set_load(1, 0, 64'h0, 30, 64'(16*c+8), 6'(2*c+9), 5'(2*c+1));
      tick();
    end
    ins = '0;
    check("prn30_count", 64'(count), 8);
    cdb0.valid = 1; cdb0.PRN = 30; cdb0.FU_result = 64'h1000;
    tick();
    cdb0 = '0;
    for (int k = 0; k < 8; k++) req_q.push_back(64'h1000 + 64'(8*k));
    Dcache_req_successful = 1;
    for (int k = 0; k < 8; k++) begin
      expect_req(1);
      check("seq_idx", 64'(proc2Dcache_index), 64'(k));
      tick();
    end
    Dcache_req_successful = 0;
    check("seq_done_vreq", 64'(valid_request), 0);
    Dcache_valid = 1; Dcache_index = 7; Dcache_data = 64'h90;
    bc_q.push_back('{data: 64'h90, prn: 6'd15, rob: 5'd7});
    tick();
    Dcache_valid = 0;
    expect_bcast(1);
    tick();
    check("seq_count", 64'(count), 7);

    // mispredict flush
    mispredict = 1;
    tick();
    mispredict = 0;
    check("flush_count", 64'(count), 0);
    check("flush_vreq", 64'(valid_request), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
